// File: rtl/muldiv_sequencer.sv
// Iterative WIDTH-bit multiply/divide unit: shift-add multiply and restoring divide
// share one 2*WIDTH accumulator, sequenced by an IDLE/PREP/RUN/FIX/DONE FSM on clk1.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t            state, state_nx;
    logic              accept;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  operand;      // multiplicand magnitude or divisor magnitude
    logic [2*WIDTH-1:0] acc;         // mul: {partial, multiplier}; div: {rem, quo}
    logic              neg_res, neg_rem;
    logic [CNTW-1:0]   counter;

    logic              is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH:0]    mul_sum, rem_shift;
    logic              rem_ge;
    logic [WIDTH-1:0]  rem_diff, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];
    // Negating the most-negative value yields itself, which is its correct unsigned magnitude.
    assign mag_a     = a_neg ? -a_q : a_q;
    assign mag_b     = b_neg ? -b_q : b_q;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
    assign rem_ge    = rem_shift >= {1'b0, operand};
    assign rem_diff  = rem_shift[WIDTH-1:0] - operand;

    assign prod_fix  = neg_res ? -acc : acc;
    assign quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = S_PREP;
            end
            S_PREP: begin
                busy     = 1'b1;
                state_nx = (is_div && b_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (counter == CNTW'(WIDTH - 1)) state_nx = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_PREP;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            operand     <= '0;
            acc         <= '0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            counter     <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (accept) begin
                    op_q        <= op;
                    a_q         <= a;
                    b_q         <= b;
                    div_by_zero <= 1'b0;
                end
                S_PREP: begin
                    counter <= '0;
                    neg_res <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    if (is_div) begin
                        operand <= mag_b;
                        acc     <= {{WIDTH{1'b0}}, mag_a};
                        if (b_q == '0) begin
                            hi          <= a_q;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end
                    end else begin
                        operand <= mag_a;
                        acc     <= {{WIDTH{1'b0}}, mag_b};
                    end
                end
                S_RUN: begin
                    counter <= counter + CNTW'(1);
                    if (is_div)
                        acc <= rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                                      : {acc[2*WIDTH-2:0], 1'b0};
                    else
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver queues expected results at issue,
// a negedge monitor pops and checks them whenever done is presented.
module tb_muldiv_sequencer;

    localparam int W = 32;

    typedef struct {
        string      name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic       dbz;
        int         e0;
        int         lmin;
        int         lmax;
    } exp_t;

    logic         clk1 = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_done = 1'b0;

    muldiv_sequencer #(.WIDTH(W), .CNTW(6)) dut (
        .clk1(clk1), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lmin, input int lmax);
        n_tests++;
        if (act < lmin || act > lmax) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lmin, lmax);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk1) begin
        if (reset) begin
            if (done && prev_done) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_width: done high on two consecutive cycles");
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with hi=%h lo=%h, expected none", hi, lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, ".hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, ".lo"}, 64'(lo), 64'(e.lo));
                    check({e.name, ".dbz"}, 64'(div_by_zero), 64'(e.dbz));
                    check_range({e.name, ".latency"}, cyc - e.e0, e.lmin, e.lmax);
                end
            end
        end
        prev_done = done & reset;
    end

    // Called at a negedge; start is accepted at the following posedge (edge E0).
    task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic expect_it,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz,
                         input int lmin, input int lmax);
        exp_t e;
        op = o; a = x; b = y; start = 1'b1;
        if (expect_it) begin
            e.name = name; e.hi = ehi; e.lo = elo; e.dbz = edbz;
            e.e0 = cyc + 1; e.lmin = lmin; e.lmax = lmax;
            sb.push_back(e);
        end
        @(negedge clk1);
        start = 1'b0;
        op = ~o; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk1);
            n++;
        end while (!done && n < 100);
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no done in %0d cycles, expected done", name, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk1);
        reset = 1'b1;
        @(negedge clk1);
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.hi", 64'(hi), 64'(0));
        check("reset.lo", 64'(lo), 64'(0));
        check("reset.dbz", 64'(div_by_zero), 64'(0));

        issue("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 34);
        check("multu_max.busy", 64'(busy), 64'(1));
        wait_done("multu_max");
        @(negedge clk1);
        check("multu_max.done_drop", 64'(done), 64'(0));

        issue("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34, 34);
        wait_done("mult_neg");
        issue("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 34);
        wait_done("div_neg");
        @(negedge clk1);

        issue("divu_zero", 2'b10, 32'h0000_0064, 32'h0000_0000, 1'b1,
              32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 2);
        wait_done("divu_zero");
        issue("divu_100_7", 2'b10, 32'h0000_0064, 32'h0000_0007, 1'b1,
              32'h0000_0002, 32'h0000_000E, 1'b0, 34, 34);
        check("divu_100_7.flag_clear", 64'(div_by_zero), 64'(0));
        check("divu_100_7.hi_hold", 64'(hi), 64'(32'h0000_0064));
        wait_done("divu_100_7");
        @(negedge clk1);

        issue("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              32'h0000_0000, 32'h8000_0000, 1'b0, 34, 34);
        wait_done("div_ovf");
        @(negedge clk1);

        issue("abort", 2'b00, 32'h0000_0006, 32'h0000_0007, 1'b0, '0, '0, 1'b0, 0, 0);
        repeat (4) @(negedge clk1);
        op = 2'b10; a = 32'h1; b = 32'h1; start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check("abort.busy_mid_run", 64'(busy), 64'(1));
        repeat (5) @(negedge clk1);
        reset = 1'b0;
        repeat (2) @(negedge clk1);
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.done", 64'(done), 64'(0));
        check("abort.hi", 64'(hi), 64'(0));
        check("abort.lo", 64'(lo), 64'(0));
        reset = 1'b1;
        repeat (40) @(negedge clk1);
        check("abort.idle_busy", 64'(busy), 64'(0));

        issue("multu_6_7", 2'b00, 32'h0000_0006, 32'h0000_0007, 1'b1,
              32'h0000_0000, 32'h0000_002A, 1'b0, 34, 34);
        wait_done("multu_6_7");
        repeat (3) @(negedge clk1);
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
